// File: rtl/acc_datapath.sv
// Accumulator-machine datapath: PC/IR/MDR/ACC/ALUREG registers, ALU and memory-port muxing.
// Define ACC_ZERO_FLAG_REG_EN to register the zero flag on pass-through (aluOp=100) cycles.
module acc_datapath (
  input  logic       clk,
  input  logic       rst,
  input  logic       pcSrc,
  input  logic       IorD,
  input  logic       memRead,
  input  logic       memWrite,
  input  logic       IRwrite,
  input  logic       pcWrite,
  input  logic       pcWriteCond,
  input  logic       accSrc,
  input  logic       ACCwrite,
  input  logic       aluSrcA,
  input  logic       aluSrcB,
  input  logic       rst_pc,
  input  logic       rst_ir,
  input  logic       rst_acc,
  input  logic       rst_mdr,
  input  logic       rst_aluReg,
  input  logic [2:0] aluOp,
  input  logic [7:0] mem_rdata,
  output logic [2:0] opc,
  output logic [4:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [4:0] pc,
  output logic [7:0] acc,
  output logic       zero
);

  logic [4:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] mdr_q, mdr_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] alureg_q, alureg_d;
  logic [7:0] alu_a, alu_b, alu_y;

  always_comb begin
    alu_a = aluSrcA ? acc_q : {3'b000, pc_q};
    alu_b = aluSrcB ? 8'd1 : mdr_q;
    case (aluOp)
      3'b000:  alu_y = alu_a + alu_b;
      3'b001:  alu_y = alu_a - alu_b;
      3'b010:  alu_y = alu_a & alu_b;
      3'b011:  alu_y = ~alu_b;
      3'b100:  alu_y = alu_a;
      default: alu_y = 8'h00;
    endcase
  end

`ifdef ACC_ZERO_FLAG_REG_EN
  logic zero_q, zero_d;

  // Flag samples ACC only while it is being passed through the ALU.
  always_comb begin
    zero_d = zero_q;
    if (aluOp == 3'b100) zero_d = (alu_y == 8'h00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) zero_q <= 1'b0;
    else     zero_q <= zero_d;
  end

  assign zero = zero_q;
`else
  assign zero = (acc_q == 8'h00);
`endif

  // All next-state terms use pre-edge values, so a fetch loads IR and PC+1 together.
  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    mdr_d    = mdr_q;
    acc_d    = acc_q;
    alureg_d = alu_y;
    if (pcWrite || (pcWriteCond && zero)) pc_d = pcSrc ? alu_y[4:0] : ir_q[4:0];
    if (IRwrite && memRead)               ir_d = mem_rdata;
    if (memRead)                          mdr_d = mem_rdata;
    if (ACCwrite)                         acc_d = accSrc ? mdr_q : alureg_q;
    if (rst_pc)     pc_d     = 5'd0;
    if (rst_ir)     ir_d     = 8'h00;
    if (rst_mdr)    mdr_d    = 8'h00;
    if (rst_acc)    acc_d    = 8'h00;
    if (rst_aluReg) alureg_d = 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= 5'd0;
      ir_q     <= 8'h00;
      mdr_q    <= 8'h00;
      acc_q    <= 8'h00;
      alureg_q <= 8'h00;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      acc_q    <= acc_d;
      alureg_q <= alureg_d;
    end
  end

  assign opc       = ir_q[7:5];
  assign mem_addr  = IorD ? ir_q[4:0] : pc_q;
  assign mem_wdata = acc_q;
  assign mem_rd    = memRead;
  assign mem_wr    = memWrite;
  assign pc        = pc_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_acc_datapath.sv
// Directed vector table for the datapath scenarios, then random control sequences
// checked against an instruction-level register model.
module tb_acc_datapath;

  typedef struct packed {
    logic       pcSrc, IorD, memRead, memWrite, IRwrite, pcWrite, pcWriteCond;
    logic       accSrc, ACCwrite, aluSrcA, aluSrcB;
    logic       rst_pc, rst_ir, rst_acc, rst_mdr, rst_aluReg;
    logic [2:0] aluOp;
  } ctl_t;

  typedef struct {
    ctl_t       c;
    logic [7:0] rd;
    logic [4:0] pc;
    logic [7:0] acc;
    logic [2:0] opc;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  ctl_t       cur = '0;
  logic [7:0] rdata = 8'h00;
  logic [2:0] opc;
  logic [4:0] mem_addr, pc;
  logic [7:0] mem_wdata, acc;
  logic       mem_rd, mem_wr, zero;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  acc_datapath dut (
    .clk(clk), .rst(rst),
    .pcSrc(cur.pcSrc), .IorD(cur.IorD), .memRead(cur.memRead), .memWrite(cur.memWrite),
    .IRwrite(cur.IRwrite), .pcWrite(cur.pcWrite), .pcWriteCond(cur.pcWriteCond),
    .accSrc(cur.accSrc), .ACCwrite(cur.ACCwrite), .aluSrcA(cur.aluSrcA), .aluSrcB(cur.aluSrcB),
    .rst_pc(cur.rst_pc), .rst_ir(cur.rst_ir), .rst_acc(cur.rst_acc),
    .rst_mdr(cur.rst_mdr), .rst_aluReg(cur.rst_aluReg),
    .aluOp(cur.aluOp), .mem_rdata(rdata),
    .opc(opc), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .pc(pc), .acc(acc), .zero(zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural registers stepped by the ALU/load rules.
  logic [4:0] m_pc;
  logic [7:0] m_ir, m_mdr, m_acc, m_alu;
  logic       m_zq;
  logic [7:0] mem [32];

  function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return 8'((int'(a) + int'(b)) % 256);
      3'd1: return 8'((int'(a) - int'(b) + 256) % 256);
      3'd2: return a & b;
      3'd3: return 8'(255 - int'(b));
      3'd4: return a;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic m_zero();
`ifdef ACC_ZERO_FLAG_REG_EN
    return m_zq;
`else
    return m_acc == 0;
`endif
  endfunction

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_mdr = 0; m_acc = 0; m_alu = 0; m_zq = 0;
  endtask

  task automatic model_step(input ctl_t c, input logic [7:0] rd);
    logic [7:0] a, b, y;
    logic [4:0] npc;
    logic [7:0] nir, nmdr, nacc;
    a = c.aluSrcA ? m_acc : {3'b000, m_pc};
    b = c.aluSrcB ? 8'd1 : m_mdr;
    y = alu(c.aluOp, a, b);
    npc = m_pc; nir = m_ir; nmdr = m_mdr; nacc = m_acc;
    if (c.pcWrite || (c.pcWriteCond && m_zero())) npc = c.pcSrc ? y[4:0] : m_ir[4:0];
    if (c.IRwrite && c.memRead) nir = rd;
    if (c.memRead) nmdr = rd;
    if (c.ACCwrite) nacc = c.accSrc ? m_mdr : m_alu;
    if (c.aluOp == 3'd4) m_zq = (y == 0);
    m_alu = c.rst_aluReg ? 8'h00 : y;
    m_pc  = c.rst_pc  ? 5'd0  : npc;
    m_ir  = c.rst_ir  ? 8'h00 : nir;
    m_mdr = c.rst_mdr ? 8'h00 : nmdr;
    m_acc = c.rst_acc ? 8'h00 : nacc;
  endtask

  vec_t tbl[$];

  task automatic add(input ctl_t c, input logic [7:0] rd, input logic [4:0] p,
                     input logic [7:0] a, input logic [2:0] o);
    vec_t v;
    v.c = c; v.rd = rd; v.pc = p; v.acc = a; v.opc = o;
    tbl.push_back(v);
  endtask

  initial begin
    ctl_t idle, fetch, rd_m, ld_mdr, ld_alu, add_c, sub_c, not_c, pass_c, jz, jmp, c;
    logic [7:0] prd;
    idle = '0;
    fetch = '0; fetch.memRead = 1; fetch.IRwrite = 1; fetch.pcWrite = 1;
    fetch.pcSrc = 1; fetch.aluSrcB = 1;
    rd_m = '0; rd_m.memRead = 1;
    ld_mdr = '0; ld_mdr.ACCwrite = 1; ld_mdr.accSrc = 1;
    ld_alu = '0; ld_alu.ACCwrite = 1;
    add_c = '0; add_c.aluSrcA = 1;
    sub_c = add_c; sub_c.aluOp = 3'd1;
    not_c = '0; not_c.aluOp = 3'd3;
    pass_c = add_c; pass_c.aluOp = 3'd4;
    jz = '0; jz.pcWriteCond = 1;
    jmp = '0; jmp.pcWrite = 1;

    for (int i = 0; i < 5; i++) add(fetch, 8'h00, 5'(i + 1), 8'h00, 3'd0);
    add(fetch, 8'hA3, 5'd6, 8'h00, 3'd5);
    add(rd_m, 8'hF0, 5'd6, 8'h00, 3'd5);
    add(ld_mdr, 8'h00, 5'd6, 8'hF0, 3'd5);
    add(rd_m, 8'h20, 5'd6, 8'hF0, 3'd5);
    add(add_c, 8'h00, 5'd6, 8'hF0, 3'd5);
    add(ld_alu, 8'h00, 5'd6, 8'h10, 3'd5);
    add(rd_m, 8'hF0, 5'd6, 8'h10, 3'd5);
    add(ld_mdr, 8'h00, 5'd6, 8'hF0, 3'd5);
    add(rd_m, 8'h20, 5'd6, 8'hF0, 3'd5);
    add(sub_c, 8'h00, 5'd6, 8'hF0, 3'd5);
    add(ld_alu, 8'h00, 5'd6, 8'hD0, 3'd5);
    add(not_c, 8'h00, 5'd6, 8'hD0, 3'd5);
    add(ld_alu, 8'h00, 5'd6, 8'hDF, 3'd5);
    c = ld_mdr; c.rst_acc = 1;
    add(c, 8'h00, 5'd6, 8'h00, 3'd5);
    add(fetch, 8'hF7, 5'd7, 8'h00, 3'd7);
    add(pass_c, 8'h00, 5'd7, 8'h00, 3'd7);
    add(jz, 8'h00, 5'd23, 8'h00, 3'd7);
    add(rd_m, 8'h01, 5'd23, 8'h00, 3'd7);
    add(ld_mdr, 8'h00, 5'd23, 8'h01, 3'd7);
    add(pass_c, 8'h00, 5'd23, 8'h01, 3'd7);
    add(jz, 8'h00, 5'd23, 8'h01, 3'd7);
    add(fetch, 8'h1F, 5'd24, 8'h01, 3'd0);
    add(jmp, 8'h00, 5'd31, 8'h01, 3'd0);
    add(fetch, 8'h00, 5'd0, 8'h01, 3'd0);
    c = fetch; c.rst_pc = 1;
    add(c, 8'h00, 5'd0, 8'h01, 3'd0);
    c = fetch; c.rst_ir = 1;
    add(c, 8'hE0, 5'd1, 8'h01, 3'd0);
`ifdef ACC_ZERO_FLAG_REG_EN
    // ACC=1 sampled by pass, then cleared: JZ must not see the new zero ACC.
    add(pass_c, 8'h00, 5'd1, 8'h01, 3'd0);
    c = idle; c.rst_acc = 1;
    add(c, 8'h00, 5'd1, 8'h00, 3'd0);
    add(jz, 8'h00, 5'd1, 8'h00, 3'd0);
`endif

    // Power-on reset
    rst = 1'b1;
    #2;
    chk("por_pc", pc, 0); chk("por_acc", acc, 0); chk("por_opc", opc, 0);
    chk("por_addr", mem_addr, 0);
`ifndef ACC_ZERO_FLAG_REG_EN
    chk("por_zero", zero, 1);
`endif
    @(negedge clk); rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      cur = tbl[i].c; rdata = tbl[i].rd;
      #1 chk("mem_rd", mem_rd, tbl[i].c.memRead);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_pc", i), pc, tbl[i].pc);
      chk($sformatf("vec%0d_acc", i), acc, tbl[i].acc);
      chk($sformatf("vec%0d_opc", i), opc, tbl[i].opc);
`ifndef ACC_ZERO_FLAG_REG_EN
      chk($sformatf("vec%0d_zero", i), zero, tbl[i].acc == 0);
`endif
    end

    // Reset pulsed between edges: registers clear without a clock edge
    @(negedge clk); cur = idle;
    #1 rst = 1'b1;
    #1 chk("pulse_pc", pc, 0); chk("pulse_acc", acc, 0); chk("pulse_opc", opc, 0);
    chk("pulse_addr", mem_addr, 0);
    chk("pulse_memwr", mem_wr, 0);
    cur.memWrite = 1; #1 chk("rst_memwr", mem_wr, 1);
    #1 rst = 1'b0; cur = idle;

    // Mid-instruction reset: an ACC load pending at reset must not land afterwards
    @(negedge clk); cur = rd_m; rdata = 8'h5A;
    @(posedge clk); #1;
    cur = ld_mdr; #1 rst = 1'b1; #1 rst = 1'b0; cur = idle;
    @(posedge clk); #1;
    chk("abandon_acc", acc, 0);
    chk("abandon_pc", pc, 0);

    // Random sequences against the model
    model_reset();
    foreach (mem[i]) mem[i] = 8'($urandom);
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 60) == 0) begin
        #1 rst = 1'b1;
        #1 chk("rnd_rst_pc", pc, 0); chk("rnd_rst_acc", acc, 0);
        rst = 1'b0;
        model_reset();
      end
      c = ctl_t'($urandom);
      c.rst_pc     = ($urandom_range(0, 15) == 0);
      c.rst_ir     = ($urandom_range(0, 15) == 0);
      c.rst_acc    = ($urandom_range(0, 15) == 0);
      c.rst_mdr    = ($urandom_range(0, 15) == 0);
      c.rst_aluReg = ($urandom_range(0, 15) == 0);
      prd = mem[c.IorD ? m_ir[4:0] : m_pc];
      if ($urandom_range(0, 7) == 0) prd = 8'h00;
      cur = c; rdata = prd;
      #1 chk("rnd_addr", mem_addr, c.IorD ? m_ir[4:0] : m_pc);
      chk("rnd_zero_pre", zero, m_zero());
      model_step(c, prd);
      @(posedge clk); #1;
      chk("rnd_pc", pc, m_pc);
      chk("rnd_acc", acc, m_acc);
      chk("rnd_opc", opc, m_ir[7:5]);
      chk("rnd_wdata", mem_wdata, m_acc);
      chk("rnd_memwr", mem_wr, c.memWrite);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/acc_datapath.md
ACC_DATAPATH -- requirements
Module: acc_datapath

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have control inputs, 1 bit each: pcSrc, IorD, memRead, memWrite, IRwrite, pcWrite, pcWriteCond, accSrc, ACCwrite, aluSrcA, aluSrcB.
REQ-003 SHALL have synchronous clear inputs, 1 bit each: rst_pc, rst_ir, rst_acc, rst_mdr, rst_aluReg.
REQ-004 SHALL have aluOp  in  3  ALU operation select.
REQ-005 SHALL have opc  out  3  IR[7:5], feeding the controller.
REQ-006 SHALL have memory-port outputs: mem_addr  out  5; mem_wdata  out  8 (=ACC); mem_rd  out  1 (=memRead); mem_wr  out  1 (=memWrite).
REQ-007 SHALL have mem_rdata  in  8, combinational read data valid in the same cycle as mem_addr.
REQ-008 SHALL have debug outputs: pc  out  5; acc  out  8; zero  out  1.

Function
REQ-009 SHALL hold registers PC[4:0], IR[7:0], MDR[7:0], ACC[7:0] and ALUREG[7:0], each updated only on posedge clk.
REQ-010 Instruction format SHALL be opc=IR[7:5], addr=IR[4:0].
REQ-011 mem_addr SHALL be PC when IorD=0, and IR[4:0] when IorD=1.
REQ-012 ALU input A SHALL be {3'b000,PC} when aluSrcA=0, and ACC when aluSrcA=1.
REQ-013 ALU input B SHALL be MDR when aluSrcB=0, and 8'd1 when aluSrcB=1.
REQ-014 ALU SHALL compute: 000 A+B; 001 A-B; 010 A&B; 011 ~B; 100 A (pass); 101-111 8'h00.
REQ-015 ALU arithmetic SHALL be modulo 256; carry and borrow SHALL be discarded.
REQ-016 IR SHALL load mem_rdata when IRwrite=1 and memRead=1; otherwise IR SHALL hold.
REQ-017 MDR SHALL load mem_rdata on every cycle with memRead=1; otherwise MDR SHALL hold.
REQ-018 ALUREG SHALL load the ALU result on every cycle.
REQ-019 ACC SHALL load when ACCwrite=1, taking MDR if accSrc=1 and ALUREG if accSrc=0.
REQ-020 PC next value SHALL be ALU result[4:0] when pcSrc=1, and IR[4:0] when pcSrc=0.
REQ-021 PC SHALL load when pcWrite=1, or when pcWriteCond=1 and zero=1.
REQ-022 PC increment SHALL wrap 31 to 0.
REQ-023 IRwrite and pcWrite in the same cycle SHALL load both IR and PC from pre-edge values: IR gets the old-PC word, PC gets old PC+1.
REQ-024 Each rst_x clear SHALL override a simultaneous load of its register, clearing it to 0 at the next edge.

Reset
REQ-025 rst SHALL immediately clear PC, IR, MDR, ACC, ALUREG and the zero register to 0, independent of clk.
REQ-026 An rst asserted mid-instruction SHALL abandon that instruction; there SHALL be no partial write after release.
REQ-027 While rst=1: opc=0, pc=0, acc=0, zero=1 (and zero register 0 per REQ-029), mem_wr equal to memWrite.

Configuration
REQ-028 Without macro ACC_ZERO_FLAG_REG_EN, zero SHALL be combinational (ACC==8'h00).
REQ-029 With ACC_ZERO_FLAG_REG_EN, zero SHALL come from a 1-bit register that loads (ALU result==0) only on cycles with aluOp=100 and holds otherwise.
REQ-030 Under REQ-029, JZ SHALL test the ACC value present during the aluOp=100 cycle, not the value at the pcWriteCond cycle.

Verification
REQ-031 Reset scenario: pulse rst between clock edges -> all registers 0 immediately; mem_addr=0.
REQ-032 Fetch scenario: PC=5, mem_rdata=8'hA3, IRwrite=memRead=pcWrite=pcSrc=aluSrcB=1, aluSrcA=0, aluOp=000 -> IR=A3, opc=101, PC=6.
REQ-033 Wrap scenario: PC=31 with fetch controls -> PC=0.
REQ-034 ADD/SUB/NOT scenario: ACC=8'hF0, MDR=8'h20 -> ADD gives ALUREG=10 then ACC=10; SUB gives D0; NOT gives DF.
REQ-035 JZ scenario, each build: ACC=0, IR=8'hF7, aluOp=100 cycle, then pcWriteCond=1, pcSrc=0 -> PC=23; with ACC=1 -> PC unchanged; with macro, ACC changed to 0 between the two cycles -> PC unchanged.
REQ-036 Clear-priority scenario: ACCwrite=1 and rst_acc=1 in the same cycle -> ACC=0.
